// File: rtl/sokoban_move_ctrl_pkg.sv
// Shared definitions for the Sokoban move controller.
//   - dir_e   : move direction encoding used by the key front end and renderer
//   - state_e : controller state encoding
//   - GRID_W  : board width/height in cells
//   - idx()   : cell index of (x,y), y*GRID_W + x
package sokoban_move_ctrl_pkg;

  localparam int GRID_W = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_WIN   = 3'd4
  } state_e;

  function automatic logic [5:0] idx(input logic [2:0] x, input logic [2:0] y);
    return (6'(y) * 6'(GRID_W)) + 6'(x);
  endfunction

endpackage

// File: rtl/sokoban_move_ctrl_if.sv
// Move request handshake between the key/debounce front end and the
// move controller.
//   move_valid   : move request (requester)
//   move_dir     : requested direction, dir_e encoding (requester)
//   move_ready   : controller can accept a move
//   move_done    : one-cycle completion pulse
//   move_blocked : qualifies move_done; 1 means nothing changed
interface sokoban_move_ctrl_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;
  logic       move_done;
  logic       move_blocked;

  modport master (
    output move_valid,
    output move_dir,
    input  move_ready,
    input  move_done,
    input  move_blocked
  );

  modport slave (
    input  move_valid,
    input  move_dir,
    output move_ready,
    output move_done,
    output move_blocked
  );
endinterface

// File: rtl/sokoban_move_ctrl_chk.sv
// Board invariants of the move controller:
//   - no box ever sits on a wall cell
//   - the number of boxes only changes when a stage is loaded
//   clk, rst : controller clock / synchronous reset
//   i_state  : controller state register
//   i_box    : box map register
//   i_wall   : wall map register
module sokoban_move_ctrl_chk
  import sokoban_move_ctrl_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input state_e      i_state,
  input logic [63:0] i_box,
  input logic [63:0] i_wall
);

  a_box_not_on_wall : assert property (@(posedge clk) disable iff (rst)
    (i_box & i_wall) == 64'd0);

  a_box_count_kept : assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && ($past(i_state) != ST_LOAD)) |->
      ($countones(i_box) == $past($countones(i_box))));

endmodule

// File: rtl/sokoban_step_calc.sv
// Combinational neighbour calculator: for a player at (i_px,i_py) moving in
// i_dir, returns the first target cell t1 (coordinates and index), the cell
// t2 beyond it, and whether either would fall off the board. Off-board
// indices are don't-care; callers must gate on the off flags.
// Also used by the renderer for cursor preview.
//   i_px, i_py : player position
//   i_dir      : direction
//   o_t1_x/y   : t1 coordinates
//   o_t1_idx   : t1 cell index
//   o_t2_idx   : t2 cell index
//   o_t1_off   : t1 off-board
//   o_t2_off   : t2 off-board
module sokoban_step_calc
  import sokoban_move_ctrl_pkg::*;
(
  input  logic [2:0] i_px,
  input  logic [2:0] i_py,
  input  dir_e       i_dir,
  output logic [2:0] o_t1_x,
  output logic [2:0] o_t1_y,
  output logic [5:0] o_t1_idx,
  output logic [5:0] o_t2_idx,
  output logic       o_t1_off,
  output logic       o_t2_off
);

  localparam logic [2:0] MAX_C = 3'(GRID_W - 1);

  logic [2:0] w_t2_x;
  logic [2:0] w_t2_y;

  // Neighbour coordinates; 3-bit arithmetic wraps, so the off flags carry
  // the edge information instead.
  always_comb begin
    o_t1_x   = i_px;
    o_t1_y   = i_py;
    w_t2_x   = i_px;
    w_t2_y   = i_py;
    o_t1_off = 1'b0;
    o_t2_off = 1'b0;
    case (i_dir)
      DIR_UP: begin
        o_t1_y   = i_py - 3'd1;
        w_t2_y   = i_py - 3'd2;
        o_t1_off = (i_py == 3'd0);
        o_t2_off = (i_py <= 3'd1);
      end
      DIR_DOWN: begin
        o_t1_y   = i_py + 3'd1;
        w_t2_y   = i_py + 3'd2;
        o_t1_off = (i_py == MAX_C);
        o_t2_off = (i_py >= (MAX_C - 3'd1));
      end
      DIR_LEFT: begin
        o_t1_x   = i_px - 3'd1;
        w_t2_x   = i_px - 3'd2;
        o_t1_off = (i_px == 3'd0);
        o_t2_off = (i_px <= 3'd1);
      end
      DIR_RIGHT: begin
        o_t1_x   = i_px + 3'd1;
        w_t2_x   = i_px + 3'd2;
        o_t1_off = (i_px == MAX_C);
        o_t2_off = (i_px >= (MAX_C - 3'd1));
      end
      default: begin
        o_t1_off = 1'b1;
        o_t2_off = 1'b1;
      end
    endcase
  end

  assign o_t1_idx = idx(o_t1_x, o_t1_y);
  assign o_t2_idx = idx(w_t2_x, w_t2_y);

endmodule

// File: rtl/sokoban_move_ctrl.sv
// Sokoban stage sequencer: loads a stage from the stage-init block and then
// executes player moves one at a time, applying wall, box-push and edge
// rules, counting successful moves and detecting the win condition.
//   clk, rst            : clock, synchronous active-high reset
//   load_req, stage_req : stage (re)load request and stage number
//   stage_sel           : registered stage number to the stage-init block
//   init_*              : stage data from the stage-init block
//   move_if (slave)     : move request/complete handshake
//   wall/dest/box/px/py : registered board state for the renderer
//   steps               : saturating successful-move count
//   won                 : high while the stage is solved
module sokoban_move_ctrl
  import sokoban_move_ctrl_pkg::*;
#(
  parameter int STEP_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [1:0]        stage_req,
  output logic [1:0]        stage_sel,
  input  logic [63:0]       init_wall,
  input  logic [63:0]       init_dest,
  input  logic [63:0]       init_box,
  input  logic [2:0]        init_px,
  input  logic [2:0]        init_py,
  sokoban_move_ctrl_if.slave move_if,
  output logic [63:0]       wall,
  output logic [63:0]       dest,
  output logic [63:0]       box,
  output logic [2:0]        px,
  output logic [2:0]        py,
  output logic [STEP_W-1:0] steps,
  output logic              won
);

  localparam logic [STEP_W-1:0] STEPS_MAX = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0] STEPS_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_next_state;
  logic [1:0]        r_stage_sel;
  logic [63:0]       r_wall;
  logic [63:0]       r_dest;
  logic [63:0]       r_box;
  logic [2:0]        r_px;
  logic [2:0]        r_py;
  logic [STEP_W-1:0] r_steps;
  dir_e              r_dir;
  logic              r_move_ready;
  logic              r_move_done;
  logic              r_move_blocked;
  logic              r_won;

  logic              w_accept_load;
  logic              w_accept_move;
  logic              w_load_win;
  logic              w_box_win;
  logic [2:0]        w_t1_x;
  logic [2:0]        w_t1_y;
  logic [5:0]        w_t1_idx;
  logic [5:0]        w_t2_idx;
  logic              w_t1_off;
  logic              w_t2_off;
  logic              w_t1_box;
  logic              w_blocked;
  logic [63:0]       w_t1_mask;
  logic [63:0]       w_t2_mask;

  sokoban_step_calc u_step_calc (
    .i_px     (r_px),
    .i_py     (r_py),
    .i_dir    (r_dir),
    .o_t1_x   (w_t1_x),
    .o_t1_y   (w_t1_y),
    .o_t1_idx (w_t1_idx),
    .o_t2_idx (w_t2_idx),
    .o_t1_off (w_t1_off),
    .o_t2_off (w_t2_off)
  );

  // A freshly loaded stage with no boxes is not treated as already solved.
  assign w_load_win = ((init_box & ~init_dest) == 64'd0) && (init_box != 64'd0);
  assign w_box_win  = ((r_box & ~r_dest) == 64'd0);

  // Off-board indices are garbage, but every use below is masked by the
  // off flags before it can matter.
  assign w_t1_box  = r_box[w_t1_idx];
  assign w_blocked = w_t1_off | r_wall[w_t1_idx] |
                     (w_t1_box & (w_t2_off | r_wall[w_t2_idx] | r_box[w_t2_idx]));
  assign w_t1_mask = 64'd1 << w_t1_idx;
  assign w_t2_mask = 64'd1 << w_t2_idx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and request acceptance; load beats move.
  always_comb begin
    w_next_state  = r_state;
    w_accept_load = 1'b0;
    w_accept_move = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_req) begin
          w_accept_load = 1'b1;
          w_next_state  = ST_LOAD;
        end else if (move_if.move_valid) begin
          w_accept_move = 1'b1;
          w_next_state  = ST_CHECK;
        end else begin
          w_next_state  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_load_win) begin
          w_next_state = ST_WIN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CHECK: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (w_box_win) begin
          w_next_state = ST_WIN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WIN: begin
        if (load_req) begin
          w_accept_load = 1'b1;
          w_next_state  = ST_LOAD;
        end else begin
          w_next_state  = ST_WIN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Board state, step counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_sel    <= 2'd0;
      r_wall         <= 64'd0;
      r_dest         <= 64'd0;
      r_box          <= 64'd0;
      r_px           <= 3'd0;
      r_py           <= 3'd0;
      r_steps        <= {STEP_W{1'b0}};
      r_dir          <= DIR_UP;
      r_move_ready   <= 1'b1;
      r_move_done    <= 1'b0;
      r_move_blocked <= 1'b0;
      r_won          <= 1'b0;
    end else begin
      if (w_accept_load) begin
        r_stage_sel <= stage_req;
      end
      if (w_accept_move) begin
        r_dir <= dir_e'(move_if.move_dir);
      end
      if (r_state == ST_LOAD) begin
        r_wall  <= init_wall;
        r_dest  <= init_dest;
        r_box   <= init_box;
        r_px    <= init_px;
        r_py    <= init_py;
        r_steps <= {STEP_W{1'b0}};
      end else if ((r_state == ST_CHECK) && !w_blocked) begin
        r_px <= w_t1_x;
        r_py <= w_t1_y;
        if (r_steps != STEPS_MAX) begin
          r_steps <= r_steps + STEPS_ONE;
        end
        if (w_t1_box) begin
          r_box <= (r_box & ~w_t1_mask) | w_t2_mask;
        end
      end
      // Outputs are registered from the next state so they line up with it.
      r_move_ready   <= (w_next_state == ST_IDLE);
      r_won          <= (w_next_state == ST_WIN);
      r_move_done    <= (r_state == ST_CHECK);
      r_move_blocked <= (r_state == ST_CHECK) && w_blocked;
    end
  end

  sokoban_move_ctrl_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .i_state (r_state),
    .i_box   (r_box),
    .i_wall  (r_wall)
  );

  assign stage_sel            = r_stage_sel;
  assign wall                 = r_wall;
  assign dest                 = r_dest;
  assign box                  = r_box;
  assign px                   = r_px;
  assign py                   = r_py;
  assign steps                = r_steps;
  assign won                  = r_won;
  assign move_if.move_ready   = r_move_ready;
  assign move_if.move_done    = r_move_done;
  assign move_if.move_blocked = r_move_blocked;

endmodule

// File: doc/sokoban_move_ctrl.md
Name: sokoban_move_ctrl

Overview:
- Sequences one Sokoban stage on the 8x8 board: requests a stage from the combinational stage-initialisation block, captures its wall, destination, box and player data, then executes player moves one at a time.
- Each move applies wall, box-push and board-edge rules, then updates the box map, player position and step count, and detects the win condition.
- Sits between the key/debounce front end (move requests) and the display/VGA renderer (which reads the state outputs).

Parameters:
- STEP_W, 10, width of the saturating step counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load_req  in  1  start-stage request; pulse or level
- stage_req  in  2  stage number to load; sampled when load_req is accepted
- stage_sel  out  2  registered stage number driven to the stage-init block
- init_wall  in  64  wall map from the stage-init block
- init_dest  in  64  destination map from the stage-init block
- init_box  in  64  initial box map
- init_px  in  3  initial player x
- init_py  in  3  initial player y
- move_valid  in  1  move request
- move_dir  in  2  0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1)
- move_ready  out  1  high only in IDLE
- move_done  out  1  one-cycle pulse when a move completes
- move_blocked  out  1  valid with move_done; 1 means no state change occurred
- wall  out  64  registered wall map
- dest  out  64  registered destination map
- box  out  64  registered box map
- px  out  3  registered player x
- py  out  3  registered player y
- steps  out  STEP_W  successful-move count
- won  out  1  high while in WIN

Behaviour:
- Cell index is y*8+x. Bit 0 is (0,0); bit 63 is (7,7).
- Reset: state=IDLE, stage_sel=0. wall, dest, box, px, py, steps, move_done, move_blocked and won are all 0. move_ready=1.
- States: IDLE, LOAD, CHECK, DONE, WIN.
- IDLE:
  - load_req has priority over move_valid.
  - On load_req: stage_sel<=stage_req, go to LOAD.
  - Else, on move_valid: latch move_dir, go to CHECK.
- LOAD (1 cycle): capture init_* into wall, dest, box, px, py; steps<=0. Next state is WIN if (init_box & ~init_dest)==0 and init_box!=0, else IDLE.
- CHECK (1 cycle), evaluated from the registered state:
  - t1 = neighbour of (px,py) in move_dir; t2 = next cell beyond t1 in the same direction.
  - A target is off-board if the coordinate would wrap: x=0 and left, x=7 and right, y=0 and up, y=7 and down. There is no wrap-around.
  - Blocked if t1 is off-board or wall[t1].
  - Blocked if box[t1] and (t2 off-board or wall[t2] or box[t2]).
  - Push (box[t1] and not blocked): box[t1]<=0, box[t2]<=1, player<=t1.
  - Walk (t1 free): player<=t1.
  - If not blocked: steps<=steps+1, saturating at all-ones.
  - blocked flag is registered for DONE.
- DONE (1 cycle): move_done=1 and move_blocked=flag. Updated state is visible this cycle. Next state is WIN if (box & ~dest)==0, else IDLE.
- Move latency: move accepted in cycle N → move_done in N+2 → move_ready again in N+3.
- WIN: won=1, move_ready=0, move_valid ignored. load_req is accepted exactly as in IDLE.
- load_req and move_valid are ignored in LOAD, CHECK and DONE. There is no queuing; the requester must hold or re-issue.
- A box never appears on a wall cell and the box count is preserved by every move. Assertions check both.
- Reset asserted mid-move aborts the move: the next cycle shows reset values and no move_done.

Decomposition:
- Shared package/include:
  - direction encodings DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT
  - state encodings
  - GRID_W=8 and the index function idx(x,y)
- Sub-module sokoban_step_calc (combinational): takes (px, py, dir) and returns t1/t2 indices plus off-board flags. It is reused by the renderer for cursor preview.

Test Plan:
- Reset then load: rst high 2 cycles, then load_req with stage_req=1 and the bench drives init_box bit 19 (3,2), px=2, py=2, wall=0, dest bit 21 → after 2 cycles box=64'h80000, px=2, py=2, steps=0, won=0, move_ready=1.
- Push: from that state, move_dir=3 → move_done at N+2, blocked=0, box bit 20 only, px=3, steps=1. A second right push moves the box to bit 21 → won=1, move_ready=0.
- Blocked cases:
  - Wall bit 4, player (3,0), move right → blocked=1, state unchanged, steps unchanged.
  - Box at (4,0), wall at (5,0), move right → blocked=1.
  - Two adjacent boxes, push into them → blocked=1.
- Edge: player (0,5) move left, player (7,7) move down, box at x=7 pushed right → all blocked=1, no wrap to another row.
- Handshake: assert move_valid and load_req together in IDLE → load wins and the move is dropped. A move_valid pulse during CHECK is ignored. load_req in WIN reloads the stage and clears won and steps.
- Saturation and reset abort: force steps to all-ones via STEP_W=2 with 4 walks → steps stays 3. Assert rst in the CHECK cycle → no move_done, all outputs reset.
